// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory unit: bus widths, the top-level
// sequencing state and the address decode helper.
package data_mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_DUMP,
    ST_DONE
  } state_t;

  // True when a byte address maps onto an implemented memory location.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/data_mem_unit_dump_streamer.sv
// Dump sequencer: walks the result window through a memory read port and
// presents one byte per beat on a valid/ready port with a registered output.
// Optional feature macro: DUMP_CHECKSUM_EN appends one modulo-256 sum beat
// after the data beats and moves dump_last onto it.
module dump_streamer
  import data_mem_pkg::*;
#(
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              complete
);

  localparam int CNT_W = $clog2(DUMP_LEN + 1);

  // Number of data bytes already loaded into the output register.
  logic [CNT_W-1:0] cnt;
  logic             advance;
  logic             more_data;
  logic             data_last;

  // The output register may take a new beat when it is empty or its
  // current beat is leaving this cycle.
  assign advance   = active & (~dump_valid | dump_ready);
  assign more_data = (cnt < CNT_W'(DUMP_LEN));
  assign rd_addr   = ADDR_W'(DUMP_BASE) + ADDR_W'(cnt);
  assign complete  = dump_valid & dump_ready & dump_last;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              sum_sent;

  // The sum beat carries the end-of-stream marker, never a data beat.
  assign data_last = 1'b0;

  // Accumulate every byte as it enters the output register; flag the sum beat once issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum      <= '0;
      sum_sent <= 1'b0;
    end else if (advance) begin
      if (more_data) begin
        sum <= sum + rd_data;
      end else if (!sum_sent) begin
        sum_sent <= 1'b1;
      end
    end
  end
`else
  assign data_last = (cnt == CNT_W'(DUMP_LEN - 1));
`endif

  // Output register and beat counter: load the next byte with no bubble,
  // hold while stalled, drop valid after the final beat leaves.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else if (advance) begin
      if (more_data) begin
        dump_valid <= 1'b1;
        dump_data  <= rd_data;
        dump_last  <= data_last;
        cnt        <= cnt + CNT_W'(1);
      end
`ifdef DUMP_CHECKSUM_EN
      else if (!sum_sent) begin
        dump_valid <= 1'b1;
        dump_data  <= sum;
        dump_last  <= 1'b1;
      end
`endif
      else begin
        dump_valid <= 1'b0;
        dump_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-wide CPU data memory with a preload port, CPU hold control and an
// end-of-run dump sequencer (LOAD -> RUN -> DUMP -> DONE).
// Optional feature macro: DUMP_CHECKSUM_EN (checksum beat in the dump stream).
module data_mem_unit
  import data_mem_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wdata,
  input  logic              write,
  output logic [DATA_W-1:0] ram_rdata,
  input  logic              finish,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_next;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic [ADDR_W-1:0] dump_rd_addr;
  logic [DATA_W-1:0] dump_rd_data;
  logic              dump_complete;

  // State register: reset always returns to preload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: last preload byte starts the CPU, finish freezes it for the
  // dump, the final dump beat ends the run.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD: if (load_valid && load_last) state_next = ST_RUN;
      ST_RUN:  if (finish)                  state_next = ST_DUMP;
      ST_DUMP: if (dump_complete)           state_next = ST_DONE;
      default: state_next = state;
    endcase
  end

  // Outputs decoded from the registered state so they change only at edges.
  always_comb begin
    load_ready = (state == ST_LOAD);
    cpu_hold   = (state != ST_RUN);
    done       = (state == ST_DONE);
  end

  // Single memory write port: preload owns it in LOAD, the CPU in RUN;
  // unmapped addresses never reach the array.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = load_addr[IDX_W-1:0];
    wr_data = load_data;
    if (state == ST_LOAD) begin
      wr_en = load_valid && addr_in_range(load_addr, DEPTH);
    end else if (state == ST_RUN) begin
      wr_en   = write && addr_in_range(ram_addr, DEPTH);
      wr_idx  = ram_addr[IDX_W-1:0];
      wr_data = ram_wdata;
    end
  end

  // Memory array write; reads below see the old byte until the next cycle.
  // NOTE: the storage array has no reset, so its contents survive reset and
  // it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign ram_rdata    = addr_in_range(ram_addr, DEPTH) ? mem[ram_addr[IDX_W-1:0]] : '0;
  assign dump_rd_data = addr_in_range(dump_rd_addr, DEPTH) ? mem[dump_rd_addr[IDX_W-1:0]] : '0;

  dump_streamer #(
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN)
  ) u_dump_streamer (
    .clk        (clk),
    .reset      (reset),
    .active     (state == ST_DUMP),
    .rd_addr    (dump_rd_addr),
    .rd_data    (dump_rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .complete   (dump_complete)
  );

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: table-driven CPU read/write vectors plus dump
// sequences checked against a scoreboard queue built from a memory model.
module tb_data_mem_unit;

  localparam int DEPTH     = 256;
  localparam int DUMP_BASE = 0;
  localparam int DUMP_LEN  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        write;
  logic [7:0]  ram_rdata;
  logic        finish;
  logic        load_valid;
  logic [15:0] load_addr;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_hold;
  logic        dump_valid;
  logic        dump_ready;
  logic [7:0]  dump_data;
  logic        dump_last;
  logic        done;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic [7:0]  exp_rdata;
  } vec_t;

  beat_t      sb[$];
  logic [7:0] model_mem [DEPTH];
  vec_t       vecs [8];

  data_mem_unit #(
    .DEPTH     (DEPTH),
    .DUMP_BASE (DUMP_BASE),
    .DUMP_LEN  (DUMP_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .write      (write),
    .ram_rdata  (ram_rdata),
    .finish     (finish),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and land 2 time units after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
    check({tag, "_dump_last"},  32'(dump_last),  32'd0);
    check({tag, "_dump_data"},  32'(dump_data),  32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
  endtask

  task automatic load_beat(input logic [15:0] addr, input logic [7:0] data, input logic last);
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_last  = last;
    #1;
    check("load_ready_in_load", 32'(load_ready), 32'd1);
    check("cpu_hold_in_load",   32'(cpu_hold),   32'd1);
    cyc();
    if (int'(addr) < DEPTH) model_mem[addr[7:0]] = data;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Pulse finish for one edge in RUN and queue the expected stream.
  task automatic start_dump();
    logic [7:0] sum;
    finish = 1'b1;
    cyc();
    finish = 1'b0;
    check("dump_entry_hold", 32'(cpu_hold), 32'd1);
    sum = 8'h00;
    for (int k = 0; k < DUMP_LEN; k++) begin
      beat_t b;
      b.data = model_mem[DUMP_BASE + k];
      sum    = sum + b.data;
`ifdef DUMP_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == DUMP_LEN - 1);
`endif
      sb.push_back(b);
    end
`ifdef DUMP_CHECKSUM_EN
    begin
      beat_t c;
      c.data = sum;
      c.last = 1'b1;
      sb.push_back(c);
    end
`endif
  endtask

  // Drive dump_ready from a repeating pattern (bit 0 first), pop and compare
  // each transferred beat, check stalled beats hold, optionally stop while
  // beat number abort_after is being presented.
  task automatic do_dump(input logic [3:0] pat, input int plen,
                         input int abort_after, input bit check_b2b);
    int         xfers;
    int         first_i;
    int         last_i;
    bit         finished;
    bit         held_v;
    logic [7:0] held_d;
    logic       held_l;
    bit         xfer;
    beat_t      exp_b;
    xfers    = 0;
    first_i  = -1;
    last_i   = -1;
    finished = 1'b0;
    held_v   = 1'b0;
    held_d   = 8'h00;
    held_l   = 1'b0;
    for (int i = 0; i < 64 && !finished; i++) begin
      dump_ready = pat[i % plen];
      #1;
      if (held_v) begin
        check("stall_valid", 32'(dump_valid), 32'd1);
        check("stall_data",  32'(dump_data),  32'(held_d));
        check("stall_last",  32'(dump_last),  32'(held_l));
      end
      if (abort_after >= 0 && xfers == abort_after && dump_valid) begin
        finished = 1'b1;
      end else begin
        xfer = dump_valid && dump_ready;
        if (xfer) begin
          if (sb.size() == 0) begin
            check("dump_extra_beat", 32'd1, 32'd0);
          end else begin
            exp_b = sb.pop_front();
            check("dump_data", 32'(dump_data), 32'(exp_b.data));
            check("dump_last", 32'(dump_last), 32'(exp_b.last));
          end
          if (first_i < 0) first_i = i;
          last_i = i;
          xfers++;
        end
        held_v = dump_valid && !dump_ready;
        held_d = dump_data;
        held_l = dump_last;
        cyc();
        if (xfer && sb.size() == 0) begin
          check("dump_end_done",  32'(done),       32'd1);
          check("dump_end_valid", 32'(dump_valid), 32'd0);
          check("dump_end_hold",  32'(cpu_hold),   32'd1);
          finished = 1'b1;
        end
      end
    end
    dump_ready = 1'b0;
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
    if (check_b2b && finished) check("dump_b2b_span", 32'(last_i - first_i), 32'(xfers - 1));
  endtask

  initial begin
    reset      = 1'b1;
    ram_addr   = 16'h0000;
    ram_wdata  = 8'h00;
    write      = 1'b0;
    finish     = 1'b0;
    load_valid = 1'b0;
    load_addr  = 16'h0000;
    load_data  = 8'h00;
    load_last  = 1'b0;
    dump_ready = 1'b0;

    vecs[0] = '{addr: 16'h0002, wdata: 8'h00, wr: 1'b0, exp_rdata: 8'h33};
    vecs[1] = '{addr: 16'h0005, wdata: 8'hA5, wr: 1'b1, exp_rdata: 8'h5A};
    vecs[2] = '{addr: 16'h0005, wdata: 8'h00, wr: 1'b0, exp_rdata: 8'hA5};
    vecs[3] = '{addr: 16'h0100, wdata: 8'h77, wr: 1'b1, exp_rdata: 8'h00};
    vecs[4] = '{addr: 16'h0100, wdata: 8'h00, wr: 1'b0, exp_rdata: 8'h00};
    vecs[5] = '{addr: 16'h0000, wdata: 8'h00, wr: 1'b0, exp_rdata: 8'h11};
    vecs[6] = '{addr: 16'hFFFF, wdata: 8'h12, wr: 1'b1, exp_rdata: 8'h00};
    vecs[7] = '{addr: 16'h0003, wdata: 8'h00, wr: 1'b0, exp_rdata: 8'h44};

    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    reset = 1'b0;

    // Preload; CPU write and finish are driven during LOAD and must be ignored.
    load_beat(16'h0005, 8'h5A, 1'b0);
    load_beat(16'h0100, 8'hEE, 1'b0);
    load_beat(16'h0000, 8'h11, 1'b0);
    load_beat(16'h0001, 8'h22, 1'b0);
    write     = 1'b1;
    ram_addr  = 16'h0000;
    ram_wdata = 8'hFF;
    finish    = 1'b1;
    load_beat(16'h0002, 8'h33, 1'b0);
    load_beat(16'h0003, 8'h44, 1'b1);
    write  = 1'b0;
    finish = 1'b0;
    check("run_load_ready", 32'(load_ready), 32'd0);
    check("run_cpu_hold",   32'(cpu_hold),   32'd0);

    // RUN: reads, read-during-write and unmapped accesses.
    for (int v = 0; v < 8; v++) begin
      ram_addr  = vecs[v].addr;
      ram_wdata = vecs[v].wdata;
      write     = vecs[v].wr;
      #1;
      check($sformatf("vec%0d_rdata", v), 32'(ram_rdata), 32'(vecs[v].exp_rdata));
      cyc();
      if (vecs[v].wr && int'(vecs[v].addr) < DEPTH) model_mem[vecs[v].addr[7:0]] = vecs[v].wdata;
    end
    write = 1'b0;

    // Full-rate dump.
    start_dump();
    do_dump(4'b1111, 1, -1, 1'b1);
    cyc();
    cyc();
    check("done_sticky",       32'(done),       32'd1);
    check("done_valid_low",    32'(dump_valid), 32'd0);
    check("done_hold",         32'(cpu_hold),   32'd1);

    // Reset, preload-free restart, dump with ready pattern 1,0,0,1.
    reset = 1'b1;
    #1;
    check_reset_outputs("rst2");
    cyc();
    reset = 1'b0;
    load_beat(16'h0200, 8'h99, 1'b1);
    check("run2_cpu_hold", 32'(cpu_hold), 32'd0);
    start_dump();
    do_dump(4'b1001, 4, -1, 1'b0);

    // Reset asynchronously while the third beat is presented.
    reset = 1'b1;
    #1;
    check_reset_outputs("rst3");
    cyc();
    reset = 1'b0;
    load_beat(16'h0200, 8'h99, 1'b1);
    start_dump();
    do_dump(4'b1111, 1, 2, 1'b0);
    check("abort_valid_before_reset", 32'(dump_valid), 32'd1);
    sb.delete();
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    cyc();
    reset = 1'b0;

    // Memory must have survived the reset.
    load_beat(16'h0200, 8'h99, 1'b1);
    ram_addr = 16'h0001;
    #1;
    check("post_reset_rdata", 32'(ram_rdata), 32'h22);
    start_dump();
    do_dump(4'b1111, 1, -1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
Byte-wide data memory that sits directly downstream of the CPU's RAM_ADDR / RAM_OUT / WRITE outputs and feeds its RAM_IN input.
- Adds a preload port so a bench or host can fill data memory before the program runs.
- Adds a dump sequencer that streams a result window out over a valid/ready port once the CPU raises FINISH.
- Holds the CPU in reset (cpu_hold) until preload completes.

Parameters:
DEPTH, 256, number of bytes implemented; addresses >= DEPTH are unmapped.
DUMP_BASE, 0, first byte address streamed out on dump.
DUMP_LEN, 16, number of bytes streamed on dump (1..DEPTH-DUMP_BASE).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
ram_addr  in  16  CPU byte address (CPU RAM_ADDR).
ram_wdata  in  8  CPU write data (CPU RAM_OUT).
write  in  1  CPU write strobe (CPU WRITE).
ram_rdata  out  8  read data to CPU RAM_IN, combinational from ram_addr.
finish  in  1  CPU FINISH.
load_valid  in  1  preload byte offered.
load_addr  in  16  preload address.
load_data  in  8  preload byte.
load_last  in  1  marks final preload byte.
load_ready  out  1  preload accepted when load_valid & load_ready.
cpu_hold  out  1  high = keep CPU in reset/stalled.
dump_valid  out  1  dump byte available.
dump_ready  in  1  consumer accepts dump byte.
dump_data  out  8  dump byte.
dump_last  out  1  marks final dump beat.
done  out  1  dump complete, sticky until reset.

Behaviour:
- State machine: LOAD -> RUN -> DUMP -> DONE. DONE is terminal until reset.
- Reset (async, any state, mid-transfer included):
  - state = LOAD, dump counter = 0.
  - load_ready = 1, cpu_hold = 1, dump_valid = 0, dump_last = 0, dump_data = 0, done = 0.
  - Memory array is not cleared.
- LOAD:
  - Each cycle with load_valid=1 writes load_data to mem[load_addr] at the clock edge; load_addr >= DEPTH is dropped silently.
  - When load_valid & load_last are accepted, the next state is RUN. On that edge load_ready and cpu_hold fall, so the CPU sees cpu_hold=0 from the next cycle.
  - CPU write and finish are ignored in LOAD.
- RUN:
  - write=1 and ram_addr < DEPTH: mem[ram_addr] <= ram_wdata at the edge.
  - Unmapped writes are ignored.
  - load_valid is ignored; load_ready = 0.
- ram_rdata:
  - Equals mem[ram_addr] in every state, 0 when unmapped.
  - Read-during-write returns the old byte; the new byte is visible the cycle after.
- RUN -> DUMP on the first cycle finish=1, level-sensitive and sampled at the edge.
- DUMP:
  - Entry edge sets cpu_hold = 1, freezing the CPU so no write races the dump.
  - First beat: dump_valid = 1 the cycle after entry, with dump_data = mem[DUMP_BASE] registered.
  - Beat transfers on dump_valid & dump_ready.
  - dump_data and dump_last hold stable while dump_ready=0.
  - After transfer k, dump_data = mem[DUMP_BASE+k+1] on the next edge, with no bubble.
  - Beats continue back-to-back while dump_ready stays high.
  - dump_last = 1 on beat DUMP_LEN-1.
- DUMP -> DONE on the last-beat transfer: dump_valid = 0 and done = 1 at that edge; cpu_hold stays 1.
- DUMP counter width: clog2(DUMP_LEN+1). No wrap is possible.

Optional Feature:
DUMP_CHECKSUM_EN:
- Defined:
  - After the data beats, one extra beat carries the 8-bit modulo-256 sum of all dumped bytes.
  - dump_last moves to this checksum beat.
  - done rises on its transfer.
- Undefined: the stream is DUMP_LEN beats only; no checksum logic is built.

Decomposition:
- Shared package data_mem_pkg:
  - state enum (ST_LOAD, ST_RUN, ST_DUMP, ST_DONE).
  - data width 8, address width 16.
  - addr_in_range function.
- One sub-module: dump_streamer. It owns the counter, output register, valid/ready handshake and the optional checksum. It is handed a memory read port by the top.

Test Plan:
1. Reset, preload mem[0x00..0x03] = 0x11,0x22,0x33,0x44 with load_last on 0x03 -> load_ready falls and cpu_hold = 0 the next cycle; ram_addr = 0x0002 gives ram_rdata = 0x33.
2. RUN: write=1, ram_addr = 0x0005, ram_wdata = 0xA5 -> same-cycle ram_rdata shows the old value; next cycle shows 0xA5. Write to ram_addr = 0x0100 with DEPTH=256 -> ignored, ram_rdata = 0x00.
3. DUMP_BASE=0, DUMP_LEN=4, finish=1, dump_ready held 1 -> cpu_hold = 1; beats are 0x11,0x22,0x33,0x44 on consecutive cycles with dump_last on 0x44; then done = 1 and dump_valid = 0.
4. Same setup, dump_ready toggled 1,0,0,1 -> each byte is held stable across the stall, with no duplicated or skipped bytes.
5. Assert reset during the third dump beat -> all outputs return to reset values immediately (asynchronously); mem[0..3] keep their contents, checked by a fresh preload-free run using load_last on an unmapped address.
6. With DUMP_CHECKSUM_EN defined, test 3 -> a fifth beat 0xAA (0x11+0x22+0x33+0x44) carries dump_last; done rises after it.
